// File: rtl/conv_pkg.sv
// Shared types and elaboration helpers for the conv3d engine and its MAC lane.
package conv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_OUTPUT,
    S_DONE
  } state_e;

  function automatic int ofm_dim(input int ifm_dim, input int wt_dim, input int stride);
    return (ifm_dim - wt_dim) / stride + 1;
  endfunction

  // Width of an index or address covering 0..depth-1, never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Registered multiply-accumulate lane: load starts a new sum, otherwise the product is added.
module conv_mac #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  output logic [DWIDTH-1:0] acc
);

  logic [DWIDTH-1:0] acc_q, acc_d, prod;

  always_comb begin
    // The low DWIDTH bits of a signed product equal those of the unsigned one.
    prod  = a * b;
    acc_d = acc_q;
    if (en) acc_d = load ? prod : acc_q + prod;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/conv3d_engine.sv
// conv3D engine: one MAC per cycle over synchronous-read IFM/weight buffers, valid/ready output.
// state    | meaning
// S_IDLE   | waiting for start
// S_FETCH  | issuing one IFM/weight read per tap, K taps per output pixel
// S_DRAIN  | no read; last returned tap is accumulated
// S_OUTPUT | pixel presented until ofm_ready
// S_DONE   | one-cycle done pulse, then idle
module conv3d_engine
  import conv_pkg::*;
#(
  parameter  int IFM_DIM   = 28,
  parameter  int IFM_DEPTH = 2,
  parameter  int OFM_DEPTH = 2,
  parameter  int WT_DIM    = 5,
  parameter  int STRIDE    = 1,
  parameter  int DWIDTH    = 32,
  localparam int OFM_DIM   = ofm_dim(IFM_DIM, WT_DIM, STRIDE),
  localparam int K         = IFM_DEPTH * WT_DIM * WT_DIM,
  localparam int IFM_AW    = addr_w(IFM_DEPTH * IFM_DIM * IFM_DIM),
  localparam int WT_AW     = addr_w(OFM_DEPTH * K),
  localparam int OFM_AW    = addr_w(OFM_DEPTH * OFM_DIM * OFM_DIM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              relu_en,
  output logic              idle,
  output logic              done,
  output logic              ifm_rd_en,
  output logic [IFM_AW-1:0] ifm_addr,
  input  logic [DWIDTH-1:0] ifm_dout,
  output logic              wt_rd_en,
  output logic [WT_AW-1:0]  wt_addr,
  input  logic [DWIDTH-1:0] wt_dout,
  output logic              ofm_valid,
  input  logic              ofm_ready,
  output logic [DWIDTH-1:0] ofm_data,
  output logic [OFM_AW-1:0] ofm_addr
);

  localparam int F_W = addr_w(OFM_DEPTH);
  localparam int O_W = addr_w(OFM_DIM);
  localparam int D_W = addr_w(IFM_DEPTH);
  localparam int T_W = addr_w(WT_DIM);
  localparam int K_W = addr_w(K);

  if (STRIDE < 1 || WT_DIM > IFM_DIM || ((IFM_DIM - WT_DIM) % STRIDE) != 0) begin : g_bad_cfg
    $error("conv3d_engine: illegal IFM_DIM/WT_DIM/STRIDE combination");
  end

  state_e            state_q, state_d;
  logic              relu_q, relu_d;
  logic [F_W-1:0]    f_q, f_d;
  logic [O_W-1:0]    i_q, i_d, j_q, j_d;
  logic [D_W-1:0]    d_q, d_d;
  logic [T_W-1:0]    m_q, m_d, n_q, n_d;
  logic [K_W-1:0]    tap_q, tap_d;
  logic              rd_en_q, rd_en_d;
  logic [IFM_AW-1:0] ifm_addr_q, ifm_addr_d;
  logic [WT_AW-1:0]  wt_addr_q, wt_addr_d;
  logic              valid_q, valid_d, done_q, done_d, idle_q, idle_d;
  logic              mac_en_q, mac_en_d, mac_load_q, mac_load_d;
  logic [DWIDTH-1:0] acc;

  always_comb begin
    state_d = state_q;
    relu_d  = relu_q;
    f_d = f_q; i_d = i_q; j_d = j_q;
    d_d = d_q; m_d = m_q; n_d = n_q;
    tap_d   = tap_q;
    rd_en_d = 1'b0;
    valid_d = 1'b0;
    done_d  = 1'b0;
    // Read data lands one cycle after the strobe, so the MAC controls trail rd_en by one.
    mac_en_d   = rd_en_q;
    mac_load_d = rd_en_q && (tap_q == '0);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          relu_d  = relu_en;
          f_d = '0; i_d = '0; j_d = '0;
          d_d = '0; m_d = '0; n_d = '0;
          tap_d   = '0;
          rd_en_d = 1'b1;
        end
      end
      S_FETCH: begin
        if (n_q == T_W'(WT_DIM - 1)) begin
          n_d = '0;
          if (m_q == T_W'(WT_DIM - 1)) begin
            m_d = '0;
            d_d = (d_q == D_W'(IFM_DEPTH - 1)) ? '0 : d_q + 1'b1;
          end else begin
            m_d = m_q + 1'b1;
          end
        end else begin
          n_d = n_q + 1'b1;
        end
        if (tap_q == K_W'(K - 1)) begin
          tap_d   = '0;
          state_d = S_DRAIN;
        end else begin
          tap_d   = tap_q + 1'b1;
          rd_en_d = 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_OUTPUT;
        valid_d = 1'b1;
      end
      S_OUTPUT: begin
        valid_d = 1'b1;
        if (ofm_ready) begin
          valid_d = 1'b0;
          if (j_q == O_W'(OFM_DIM - 1)) begin
            j_d = '0;
            if (i_q == O_W'(OFM_DIM - 1)) begin
              i_d = '0;
              f_d = (f_q == F_W'(OFM_DEPTH - 1)) ? '0 : f_q + 1'b1;
            end else begin
              i_d = i_q + 1'b1;
            end
          end else begin
            j_d = j_q + 1'b1;
          end
          if (f_q == F_W'(OFM_DEPTH - 1) && i_q == O_W'(OFM_DIM - 1) && j_q == O_W'(OFM_DIM - 1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_FETCH;
            rd_en_d = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    idle_d     = (state_d == S_IDLE);
    ifm_addr_d = IFM_AW'(int'(d_d) * IFM_DIM * IFM_DIM
                         + (int'(i_d) * STRIDE + int'(m_d)) * IFM_DIM
                         + int'(j_d) * STRIDE + int'(n_d));
    wt_addr_d  = WT_AW'(int'(f_d) * K + int'(d_d) * WT_DIM * WT_DIM
                        + int'(m_d) * WT_DIM + int'(n_d));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      relu_q     <= 1'b0;
      f_q        <= '0;
      i_q        <= '0;
      j_q        <= '0;
      d_q        <= '0;
      m_q        <= '0;
      n_q        <= '0;
      tap_q      <= '0;
      rd_en_q    <= 1'b0;
      ifm_addr_q <= '0;
      wt_addr_q  <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      idle_q     <= 1'b1;
      mac_en_q   <= 1'b0;
      mac_load_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      relu_q     <= relu_d;
      f_q        <= f_d;
      i_q        <= i_d;
      j_q        <= j_d;
      d_q        <= d_d;
      m_q        <= m_d;
      n_q        <= n_d;
      tap_q      <= tap_d;
      rd_en_q    <= rd_en_d;
      ifm_addr_q <= ifm_addr_d;
      wt_addr_q  <= wt_addr_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      idle_q     <= idle_d;
      mac_en_q   <= mac_en_d;
      mac_load_q <= mac_load_d;
    end
  end

  conv_mac #(.DWIDTH(DWIDTH)) u_mac (
    .clk  (clk),
    .rst  (rst),
    .en   (mac_en_q),
    .load (mac_load_q),
    .a    (ifm_dout),
    .b    (wt_dout),
    .acc  (acc)
  );

  assign idle      = idle_q;
  assign done      = done_q;
  assign ifm_rd_en = rd_en_q;
  assign wt_rd_en  = rd_en_q;
  assign ifm_addr  = ifm_addr_q;
  assign wt_addr   = wt_addr_q;
  assign ofm_valid = valid_q;
  assign ofm_data  = (relu_q && acc[DWIDTH-1]) ? '0 : acc;
  assign ofm_addr  = OFM_AW'(int'(f_q) * OFM_DIM * OFM_DIM + int'(i_q) * OFM_DIM + int'(j_q));

endmodule
